bus_if_mc: RTL and testbench
============================

Name: bus_if_mc

Overview:
- Next-generation CPU-side memory access interface, instantiated per pipeline port (IF and MEM).
- Decodes the slave index from the word address and routes each access to one of two places:
  - the local scratchpad (SPM), zero-wait, combinational path;
  - the shared bus, through a registered request/grant/access FSM.
- Adds over the previous generation: width/index parameters, byte enables, a configurable SPM slave index, a bus-access timeout with error flag, and flush-abort of a not-yet-granted request.

Parameters:
ADDR_W, 30, word address width
DATA_W, 32, data width; multiple of 8
IDX_W, 3, slave-index width, taken from addr[ADDR_W-1 -: IDX_W]
SPM_IDX, 1, slave index that selects the scratchpad
TIMEOUT, 255, max ACCESS cycles waiting for bus_rdy_; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline stall
flush  in  1  pipeline flush
busy  out  1  access not complete, pipeline must stall
err  out  1  one-cycle pulse: bus access timed out
addr  in  ADDR_W  word address
as_  in  1  address strobe, active low
rw  in  1  1=READ, 0=WRITE
be  in  DATA_W/8  byte enables for writes
wr_data  in  DATA_W  write data
rd_data  out  DATA_W  read data
spm_rd_data  in  DATA_W  SPM read data
spm_addr/spm_rw/spm_wr_data/spm_be  out  ADDR_W/1/DATA_W/DATA_W/8  direct pass-through of addr/rw/wr_data/be
spm_as_  out  1  SPM strobe, active low
bus_rd_data  in  DATA_W  bus read data
bus_rdy_  in  1  bus ready, active low
bus_grnt_  in  1  arbiter grant, active low
bus_req_  out  1  bus request, active low, registered
bus_addr/bus_rw/bus_wr_data/bus_be  out  ADDR_W/1/DATA_W/DATA_W/8  registered, latched at grant
bus_as_  out  1  bus strobe, active low, registered

Behaviour:
- Reset values: state=IDLE, bus_req_=1, bus_as_=1, bus_addr=0, bus_rw=READ, bus_wr_data=0, bus_be=0, rd_buf=0, err=0, timeout count=0.
- Combinational outputs default to: rd_data=0, spm_as_=1, busy=0.

- IDLE, when as_=0 and flush=0:
  - SPM hit (index==SPM_IDX):
    - If stall=0: spm_as_=0, and rd_data=spm_rd_data when READ (0 latency).
    - If stall=1: busy=1, and no SPM strobe.
  - Bus access (other index): busy=1, bus_req_<=0, go to REQ.
  - flush=1 or as_=1: do nothing.
- REQ:
  - busy=1.
  - flush=1 before grant: bus_req_<=1, return to IDLE. The abort is visible the next cycle.
  - bus_grnt_=0: latch addr/rw/wr_data/be into bus_* and set bus_as_<=0 for exactly one cycle, go to ACCESS. Grant has priority over flush in the same cycle.
- ACCESS:
  - bus_as_<=1.
  - flush is ignored; a granted transfer always completes.
  - bus_rdy_=0:
    - busy=0, rd_data=bus_rd_data (READ).
    - rd_buf<=bus_rd_data, bus_req_<=1.
    - Next state: STALL if stall=1, else IDLE.
  - bus_rdy_=1: busy=1, count++.
  - Timeout fires when count==TIMEOUT-1 with bus_rdy_ still 1:
    - err=1 for this cycle, busy=0, rd_data=0.
    - rd_buf<=0, bus_req_<=1.
    - Next state: STALL if stall=1, else IDLE.
  - Count clears on leaving ACCESS.
- STALL:
  - busy=0, rd_data=rd_buf (READ).
  - Stay while stall=1; go to IDLE when stall=0.
- Reset mid-transaction: everything returns to reset values immediately; bus_req_ and bus_as_ deassert asynchronously.
- rdy and timeout in the same cycle: rdy wins, err=0.
- be is ignored for READ. bus_be is driven as latched.

Decomposition:
- Shared header bus_if_mc.h:
  - state encodings BUS_IF_STATE_IDLE/REQ/ACCESS/STALL (2 bits);
  - READ/WRITE, ENABLE_/DISABLE_ constants;
  - default widths.
- One sub-module, bus_if_wdt:
  - parameterised TIMEOUT counter;
  - inputs clear/enable, output expire;
  - TIMEOUT=0 ties expire low.

Test Plan:
- Reset, then SPM read: addr index=SPM_IDX, as_=0, rw=1, spm_rd_data=32'hCAFE_0001 → same cycle spm_as_=0, rd_data=CAFE_0001, busy=0. Repeat with stall=1 → busy=1, spm_as_=1.
- Bus read: index 2, grant 2 cycles after req, bus_rdy_ low 3 cycles after grant, data 32'h1234_5678 → busy=1 throughout; bus_as_ low exactly one cycle; rd_data=1234_5678 on the rdy cycle; bus_req_ high the next cycle.
- Bus write with be=4'b0101, wr_data=32'hA5A5_A5A5 → bus_rw=0, bus_be=0101, bus_wr_data=A5A5A5A5 latched at grant and stable through ACCESS.
- rdy while stall=1 → STALL; rd_data=rd_buf held for 4 stalled cycles; IDLE after stall falls.
- Timeout with TIMEOUT=8, no rdy → err high exactly one cycle, 8 cycles after entering ACCESS; busy=0; rd_data=0; bus_req_=1; same cycle with rdy=0 → err=0.
- Flush in REQ before grant → bus_req_ returns to 1, IDLE, no bus_as_. Reset asserted during ACCESS → bus_req_ and bus_as_ high immediately.

Source files
------------

// File: rtl/bus_if_mc_pkg.sv
// Shared definitions for the bus_if_mc memory access interface.
package bus_if_mc_pkg;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 3;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_REQ    = 2'd1,
    STATE_ACCESS = 2'd2,
    STATE_STALL  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_if_wdt.sv
// Bus access watchdog: counts enabled cycles and flags expiry at TIMEOUT-1.
// TIMEOUT=0 disables the watchdog entirely.
module bus_if_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] count;

      // Wait-cycle counter; clear has priority over enable
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + CW'(1);
        end
      end

      assign expire = (count == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/bus_if_mc.sv
// CPU-side memory access interface: zero-wait scratchpad path plus a
// request/grant/access bus FSM with timeout and flush-abort.
module bus_if_mc
  import bus_if_mc_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned SPM_IDX = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  output logic                busy,
  output logic                err,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                as_,
  input  logic                rw,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [DATA_W-1:0]   spm_rd_data,
  output logic [ADDR_W-1:0]   spm_addr,
  output logic                spm_as_,
  output logic                spm_rw,
  output logic [DATA_W-1:0]   spm_wr_data,
  output logic [DATA_W/8-1:0] spm_be,
  input  logic [DATA_W-1:0]   bus_rd_data,
  input  logic                bus_rdy_,
  input  logic                bus_grnt_,
  output logic                bus_req_,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [DATA_W-1:0]   bus_wr_data,
  output logic [DATA_W/8-1:0] bus_be
);

  state_t             state;
  logic [DATA_W-1:0]  rd_buf;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic               start;
  logic               rdy;
  logic               expire;
  logic               wdt_clear;
  logic               wdt_en;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_be      = be;

  assign idx   = addr[ADDR_W-1 -: IDX_W];
  assign hit   = (idx == IDX_W'(SPM_IDX));
  assign start = (as_ == ENABLE_) && !flush;
  assign rdy   = (bus_rdy_ == ENABLE_);

  bus_if_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdt_clear),
    .enable (wdt_en),
    .expire (expire)
  );

  // Combinational outputs: SPM strobe, read data mux, busy/err, watchdog control
  always_comb begin
    rd_data   = '0;
    spm_as_   = DISABLE_;
    busy      = 1'b0;
    err       = 1'b0;
    wdt_clear = 1'b1;
    wdt_en    = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (start) begin
          if (hit && !stall) begin
            spm_as_ = ENABLE_;
            if (rw == READ) rd_data = spm_rd_data;
          end else begin
            busy = 1'b1;
          end
        end
      end
      STATE_REQ: busy = 1'b1;
      STATE_ACCESS: begin
        // ready beats a simultaneous timeout
        if (rdy) begin
          if (bus_rw == READ) rd_data = bus_rd_data;
        end else if (expire) begin
          err = 1'b1;
        end else begin
          busy      = 1'b1;
          wdt_clear = 1'b0;
          wdt_en    = 1'b1;
        end
      end
      STATE_STALL: begin
        if (bus_rw == READ) rd_data = rd_buf;
      end
      default: ;
    endcase
  end

  // Bus FSM with registered request/strobe and grant-time address/data latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= STATE_IDLE;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_addr    <= '0;
      bus_rw      <= READ;
      bus_wr_data <= '0;
      bus_be      <= '0;
      rd_buf      <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (start && !hit) begin
            bus_req_ <= ENABLE_;
            state    <= STATE_REQ;
          end
        end
        STATE_REQ: begin
          if (bus_grnt_ == ENABLE_) begin
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
            bus_be      <= be;
            bus_as_     <= ENABLE_;
            state       <= STATE_ACCESS;
          end else if (flush) begin
            bus_req_ <= DISABLE_;
            state    <= STATE_IDLE;
          end
        end
        STATE_ACCESS: begin
          bus_as_ <= DISABLE_;
          if (rdy || expire) begin
            rd_buf   <= rdy ? bus_rd_data : '0;
            bus_req_ <= DISABLE_;
            state    <= stall ? STATE_STALL : STATE_IDLE;
          end
        end
        STATE_STALL: begin
          if (!stall) state <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if_mc.sv
// Self-checking bench for bus_if_mc: SPM vector table, directed bus
// sequences and randomized transactions against a timeline model.
module tb_bus_if_mc;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy, err;
  logic [29:0] addr;
  logic        as_, rw;
  logic [3:0]  be;
  logic [31:0] wr_data, rd_data, spm_rd_data;
  logic [29:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data;
  logic [3:0]  spm_be;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_, bus_grnt_, bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  bus_if_mc #(.SPM_IDX(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy), .err(err),
    .addr(addr), .as_(as_), .rw(rw), .be(be), .wr_data(wr_data), .rd_data(rd_data),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_be(spm_be), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_be(bus_be)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [29:0] mk_addr(input logic [2:0] idx);
    logic [26:0] low;
    low = 27'($urandom);
    return {idx, low};
  endfunction

  // One bus transaction. Timeline: cycle 0 IDLE request, g REQ cycles without
  // grant, grant at cycle 1+g, ACCESS from 2+g, rdy in ACCESS cycle r.
  // Completes after min(r, TMO-1) ACCESS cycles; timeout if r > TMO-1.
  // nst>0 keeps stall high on the completion cycle and nst-1 cycles after.
  task automatic run_bus(input logic [29:0] a, input logic r_w, input logic [31:0] wd,
                         input logic [3:0] b, input logic [31:0] rdat,
                         input int unsigned g, input int unsigned r, input int unsigned nst);
    int unsigned t_acc, t_done;
    logic        to;
    logic [31:0] res;
    t_acc  = 2 + g;
    to     = (r > TMO - 1);
    t_done = t_acc + (to ? TMO - 1 : r);
    res    = (r_w && !to) ? rdat : 32'h0;
    for (int unsigned c = 0; c <= t_done; c++) begin
      @(negedge clk);
      as_ = 1'b0; addr = a; rw = r_w; wr_data = wd; be = b; flush = 1'b0;
      spm_rd_data = $urandom;
      stall       = (c == t_done) && (nst > 0);
      bus_grnt_   = (c == 1 + g) ? 1'b0 : 1'b1;
      bus_rdy_    = (c == t_acc + r) ? 1'b0 : 1'b1;
      bus_rd_data = (c == t_acc + r) ? rdat : $urandom;
      #1;
      chk("busy", busy, c < t_done);
      chk("bus_req_", bus_req_, c == 0);
      chk("bus_as_", bus_as_, c != t_acc);
      chk("err", err, (c == t_done) && to);
      chk("spm_as_", spm_as_, 1'b1);
      if (c == t_done) chk("rd_data_done", rd_data, res);
      if (c >= t_acc) begin
        chk("bus_addr", bus_addr, a);
        chk("bus_rw", bus_rw, r_w);
        chk("bus_wr_data", bus_wr_data, wd);
        chk("bus_be", bus_be, b);
      end
    end
    if (nst > 0) begin
      for (int unsigned c = 0; c < nst; c++) begin
        @(negedge clk);
        as_ = 1'b1; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = $urandom;
        stall = (c < nst - 1);
        #1;
        chk("stall_busy", busy, 1'b0);
        chk("stall_rd_data", rd_data, res);
        chk("stall_bus_req_", bus_req_, 1'b1);
      end
    end
    @(negedge clk);
    as_ = 1'b1; stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = $urandom;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_rd_data", rd_data, 32'h0);
    chk("idle_bus_req_", bus_req_, 1'b1);
    chk("idle_err", err, 1'b0);
  endtask

  typedef struct {
    logic        strobe;
    logic        fl;
    logic        st;
    logic        r_w;
    logic [2:0]  idx;
    logic [31:0] spm;
    logic        exp_spm_as;
    logic        exp_busy;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'hCAFE_0001, 1'b1, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 32'h1111_2222, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 32'h3333_4444, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h5555_6666, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h7777_8888, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 32'h9999_AAAA, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};

    reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1; be = 4'h0;
    addr = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
    #1;
    chk("rst_bus_req_", bus_req_, 1'b1);
    chk("rst_bus_as_", bus_as_, 1'b1);
    chk("rst_bus_addr", bus_addr, 30'h0);
    chk("rst_bus_rw", bus_rw, 1'b1);
    chk("rst_bus_wr_data", bus_wr_data, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // SPM / idle vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      as_ = vecs[i].strobe; flush = vecs[i].fl; stall = vecs[i].st; rw = vecs[i].r_w;
      addr = mk_addr(vecs[i].idx); spm_rd_data = vecs[i].spm;
      wr_data = $urandom; be = 4'($urandom);
      #1;
      chk("vec_spm_as_", spm_as_, vecs[i].exp_spm_as);
      chk("vec_busy", busy, vecs[i].exp_busy);
      chk("vec_rd_data", rd_data, vecs[i].exp_rd);
      chk("vec_bus_req_", bus_req_, 1'b1);
      chk("vec_spm_pass", {spm_addr, spm_rw, spm_be, spm_wr_data}, {addr, rw, be, wr_data});
    end
    @(negedge clk);
    as_ = 1'b1; flush = 1'b0; stall = 1'b0;

    // Directed bus transactions
    run_bus(mk_addr(3'd2), 1'b1, 32'h0, 4'h0, 32'h1234_5678, 2, 3, 0);
    run_bus(mk_addr(3'd4), 1'b0, 32'hA5A5_A5A5, 4'b0101, 32'hFFFF_0000, 1, 2, 0);
    run_bus(mk_addr(3'd0), 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 0, 1, 5);
    run_bus(mk_addr(3'd7), 1'b1, 32'h0, 4'h0, 32'h7777_7777, 1, 20, 0);
    run_bus(mk_addr(3'd6), 1'b1, 32'h0, 4'h0, 32'h6666_1234, 0, TMO - 1, 0);
    run_bus(mk_addr(3'd3), 1'b1, 32'h0, 4'h0, 32'h4242_4242, 0, TMO, 3);
    run_bus(mk_addr(3'd5), 1'b0, 32'h1357_9BDF, 4'b1100, 32'h2468_ACE0, 0, TMO - 2, 2);

    // Flush before grant aborts the request
    @(negedge clk);
    as_ = 1'b0; addr = mk_addr(3'd4); rw = 1'b1; flush = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_req_busy", busy, 1'b1);
    chk("flush_req_bus_req_", bus_req_, 1'b0);
    @(negedge clk);
    as_ = 1'b1; flush = 1'b0;
    #1;
    chk("flush_abort_bus_req_", bus_req_, 1'b1);
    chk("flush_abort_bus_as_", bus_as_, 1'b1);
    chk("flush_abort_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    chk("flush_abort_bus_as_2", bus_as_, 1'b1);

    // Grant beats flush in the same cycle; flush ignored during ACCESS
    @(negedge clk);
    as_ = 1'b0; addr = mk_addr(3'd6); rw = 1'b1;
    @(negedge clk);
    bus_grnt_ = 1'b0; flush = 1'b1;
    @(negedge clk);
    bus_grnt_ = 1'b1;
    #1;
    chk("gf_bus_as_", bus_as_, 1'b0);
    chk("gf_busy", busy, 1'b1);
    @(negedge clk);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h5555_AAAA;
    #1;
    chk("gf_busy_done", busy, 1'b0);
    chk("gf_rd_data", rd_data, 32'h5555_AAAA);
    @(negedge clk);
    as_ = 1'b1; flush = 1'b0; bus_rdy_ = 1'b1;
    #1;
    chk("gf_bus_req_", bus_req_, 1'b1);

    // Asynchronous reset during ACCESS
    @(negedge clk);
    as_ = 1'b0; addr = mk_addr(3'd3); rw = 1'b0; wr_data = 32'hFACE_0000; be = 4'hF;
    @(negedge clk);
    bus_grnt_ = 1'b0;
    @(negedge clk);
    bus_grnt_ = 1'b1;
    #1;
    chk("ra_bus_as_before", bus_as_, 1'b0);
    as_ = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("ra_bus_req_", bus_req_, 1'b1);
    chk("ra_bus_as_", bus_as_, 1'b1);
    chk("ra_bus_addr", bus_addr, 30'h0);
    chk("ra_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized mix of SPM hits and bus transactions
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  idx;
      logic        r_w, st;
      logic [31:0] d;
      idx = 3'($urandom_range(0, 7));
      r_w = 1'($urandom);
      d   = $urandom;
      if (idx == 3'd1) begin
        st = 1'($urandom);
        @(negedge clk);
        as_ = 1'b0; flush = 1'b0; stall = st; rw = r_w; addr = mk_addr(idx); spm_rd_data = d;
        #1;
        chk("rnd_spm_as_", spm_as_, st);
        chk("rnd_spm_busy", busy, st);
        chk("rnd_spm_rd_data", rd_data, (!st && r_w) ? d : 32'h0);
        @(negedge clk);
        as_ = 1'b1; stall = 1'b0;
      end else begin
        run_bus(mk_addr(idx), r_w, $urandom, 4'($urandom), d,
                $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
